// File: rtl/sparse_mult_by_e_qc_if.sv
// Handshake and table-programming bus for sparse_mult_by_e_qc.
// The design side (slave) consumes input blocks and config writes, and produces output blocks.
interface sparse_mult_by_e_qc_if #(
    parameter int WIDTH        = 16,
    parameter int NUM_IN_BLKS  = 4,
    parameter int NUM_OUT_BLKS = 2
);
    localparam int SW = $clog2(WIDTH);
    localparam int AW = $clog2(NUM_IN_BLKS*NUM_OUT_BLKS);

    logic [WIDTH-1:0] i_in_data;
    logic             i_in_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] o_out_data;
    logic             o_out_valid;
    logic             o_out_last;
    logic             i_out_ready;
    logic             i_cfg_we;
    logic [AW-1:0]    i_cfg_addr;
    logic             i_cfg_en;
    logic [SW-1:0]    i_cfg_shift;

    modport slave (
        input  i_in_data, i_in_valid, i_out_ready,
        input  i_cfg_we, i_cfg_addr, i_cfg_en, i_cfg_shift,
        output o_in_ready, o_out_data, o_out_valid, o_out_last
    );

    modport master (
        output i_in_data, i_in_valid, i_out_ready,
        output i_cfg_we, i_cfg_addr, i_cfg_en, i_cfg_shift,
        input  o_in_ready, o_out_data, o_out_valid, o_out_last
    );
endinterface

// File: rtl/sparse_mult_by_e_qc.sv
// Quasi-cyclic sparse multiply-by-E: accumulates rotated input blocks into NUM_OUT_BLKS
// row accumulators over a frame, then drains the rows one per output handshake.
module sparse_mult_by_e_qc #(
    parameter int WIDTH        = 16,
    parameter int NUM_IN_BLKS  = 4,
    parameter int NUM_OUT_BLKS = 2
) (
    input logic                   i_clock,
    input logic                   i_reset,
    sparse_mult_by_e_qc_if.slave  bus
);
    localparam int NE = NUM_IN_BLKS*NUM_OUT_BLKS;
    localparam int SW = $clog2(WIDTH);
    localparam int CW = (NUM_IN_BLKS  > 1) ? $clog2(NUM_IN_BLKS)  : 1;
    localparam int RW = (NUM_OUT_BLKS > 1) ? $clog2(NUM_OUT_BLKS) : 1;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]                            state_q, state_d;
    logic [CW-1:0]                         col_q, col_d;
    logic [RW-1:0]                         row_q, row_d;
    logic [NUM_OUT_BLKS-1:0][WIDTH-1:0]    acc_q, acc_d;
    logic [NE-1:0]                         en_q, en_d;
    logic [NE-1:0][SW-1:0]                 shift_q, shift_d;
    logic [NE-1:0]                         live;
    logic                                  in_rdy, in_fire, out_fire, cfg_ok, last_col, last_row;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input logic [SW-1:0] s);
        logic [2*WIDTH-1:0] dbl;
        dbl = {x, x} << s;
        return dbl[2*WIDTH-1:WIDTH];
    endfunction

    // Out-of-range shifts (only possible for non-power-of-two WIDTH) disable the circulant.
    always_comb begin
        for (int i = 0; i < NE; i++)
            live[i] = en_q[i] && (32'(shift_q[i]) < WIDTH);
    end

    assign in_rdy   = (state_q == ST_ACCUM) && !i_reset;
    assign in_fire  = in_rdy && bus.i_in_valid;
    assign out_fire = (state_q == ST_DRAIN) && bus.i_out_ready;
    assign last_col = (col_q == CW'(NUM_IN_BLKS-1));
    assign last_row = (row_q == RW'(NUM_OUT_BLKS-1));
    assign cfg_ok   = bus.i_cfg_we && (state_q == ST_ACCUM) && (col_q == '0)
                      && (32'(bus.i_cfg_addr) < NE);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        acc_d   = acc_q;
        en_d    = en_q;
        shift_d = shift_q;

        if (cfg_ok) begin
            en_d[bus.i_cfg_addr]    = bus.i_cfg_en;
            shift_d[bus.i_cfg_addr] = bus.i_cfg_shift;
        end

        if (in_fire) begin
            for (int r = 0; r < NUM_OUT_BLKS; r++)
                if (live[r*NUM_IN_BLKS + int'(col_q)])
                    acc_d[r] = acc_q[r] ^ rotl(bus.i_in_data, shift_q[r*NUM_IN_BLKS + int'(col_q)]);
            if (last_col) begin
                col_d   = '0;
                state_d = ST_DRAIN;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (out_fire) begin
            if (last_row) begin
                row_d   = '0;
                acc_d   = '0;
                state_d = ST_ACCUM;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_ACCUM;
            col_q   <= '0;
            row_q   <= '0;
            acc_q   <= '0;
            en_q    <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            en_q    <= en_d;
            shift_q <= shift_d;
        end
    end

    assign bus.o_in_ready  = in_rdy;
    assign bus.o_out_valid = (state_q == ST_DRAIN);
    assign bus.o_out_last  = (state_q == ST_DRAIN) && last_row;
    assign bus.o_out_data  = (state_q == ST_DRAIN) ? acc_q[row_q] : '0;
endmodule

// File: tb/tb_sparse_mult_by_e_qc.sv
// Directed bench for sparse_mult_by_e_qc: stimulus pushes expected rows, a monitor pops on handshake.
module tb_sparse_mult_by_e_qc;
    localparam int W = 16, NI = 4, NO = 2;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    sparse_mult_by_e_qc_if #(.WIDTH(W), .NUM_IN_BLKS(NI), .NUM_OUT_BLKS(NO)) bus ();

    sparse_mult_by_e_qc #(.WIDTH(W), .NUM_IN_BLKS(NI), .NUM_OUT_BLKS(NO)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: sample on the falling edge, the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus.o_in_ready && bus.o_out_valid) begin
                errors++;
                $display("FAIL ready_valid_excl: in_ready=1 and out_valid=1 together");
            end
            if (bus.o_out_valid && bus.i_out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: got %h with no expected entry", bus.o_out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", bus.o_out_data, e.data);
                    chk("out_last", {{(W-1){1'b0}}, bus.o_out_last}, {{(W-1){1'b0}}, e.last});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        int n;
        bit done;
        n = 0; done = 0;
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = d;
        while (!done) begin
            @(negedge clk);
            if (bus.o_in_ready) done = 1;
            else if (++n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stayed 0, required 1");
                done = 1;
            end
        end
        cyc();
        bus.i_in_valid = 1'b0;
    endtask

    task automatic cfg(input int addr, input logic en, input logic [3:0] sh);
        bus.i_cfg_we    = 1'b1;
        bus.i_cfg_addr  = 3'(addr);
        bus.i_cfg_en    = en;
        bus.i_cfg_shift = sh;
        cyc();
        bus.i_cfg_we = 1'b0;
    endtask

    task automatic expect_frame(input logic [W-1:0] o0, input logic [W-1:0] o1);
        sb.push_back('{data: o0, last: 1'b0});
        sb.push_back('{data: o1, last: 1'b1});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            cyc(); n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d rows pending, required 0", sb.size());
            sb.delete();
        end
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            cyc();
            chk("rst_in_ready",  {15'b0, bus.o_in_ready},  16'h0);
            chk("rst_out_valid", {15'b0, bus.o_out_valid}, 16'h0);
            chk("rst_out_last",  {15'b0, bus.o_out_last},  16'h0);
            chk("rst_out_data",  bus.o_out_data,           16'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        int pulses;
        bus.i_in_valid  = 1'b0;
        bus.i_in_data   = '0;
        bus.i_out_ready = 1'b1;
        bus.i_cfg_we    = 1'b0;
        bus.i_cfg_addr  = '0;
        bus.i_cfg_en    = 1'b0;
        bus.i_cfg_shift = '0;

        // Reset state, then a long idle period with no output activity.
        do_reset();
        chk("in_ready_after_rst", {15'b0, bus.o_in_ready}, 16'h1);
        pulses = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.o_out_valid) pulses++;
        end
        chk("idle_valid_pulses", 16'(pulses), 16'h0);
        cyc();

        // Cleared table: everything sums to zero; first row valid right after the 4th accept.
        expect_frame(16'h0000, 16'h0000);
        repeat (NI) send(16'hFFFF);
        chk("latency_valid", {15'b0, bus.o_out_valid}, 16'h1);
        chk("latency_data",  bus.o_out_data, 16'h0000);
        wait_drain();

        // Single circulant, shift 1: 0x8001 rotated left wraps bit 15 into bit 0.
        cfg(0, 1'b1, 4'd1);
        expect_frame(16'h0003, 16'h0000);
        send(16'h8001); send(16'h0000); send(16'h0000); send(16'h0000);
        wait_drain();

        // Two blocks XORed into row 0, shift 15 on row 1.
        cfg(0, 1'b1, 4'd0);
        cfg(1, 1'b1, 4'd0);
        cfg(7, 1'b1, 4'd15);
        expect_frame(16'h0FF0, 16'h8000);
        send(16'h00F0); send(16'h0F00); send(16'h1234); send(16'h0001);
        wait_drain();

        // Back-pressure: row 0 held, input pulses ignored, then the drain resumes.
        bus.i_out_ready = 1'b0;
        expect_frame(16'h0FF0, 16'h8000);
        send(16'h00F0); send(16'h0F00); send(16'h1234); send(16'h0001);
        repeat (3) begin
            chk("stall_valid",    {15'b0, bus.o_out_valid}, 16'h1);
            chk("stall_data",     bus.o_out_data,           16'h0FF0);
            chk("stall_last",     {15'b0, bus.o_out_last},  16'h0);
            chk("stall_in_ready", {15'b0, bus.o_in_ready},  16'h0);
            bus.i_in_valid = 1'b1;
            bus.i_in_data  = 16'hFFFF;
            cyc();
        end
        bus.i_in_valid  = 1'b0;
        bus.i_out_ready = 1'b1;
        wait_drain();
        expect_frame(16'h0FF0, 16'h8000);
        send(16'h00F0); send(16'h0F00); send(16'h1234); send(16'h0001);
        wait_drain();

        // Mid-frame write to (1,1) must be dropped: row 1 stays zero.
        cfg(0, 1'b1, 4'd1);
        cfg(1, 1'b0, 4'd0);
        cfg(7, 1'b0, 4'd0);
        expect_frame(16'h0002, 16'h0000);
        send(16'h0001);
        cfg(5, 1'b1, 4'd0);
        send(16'h0010); send(16'h0000); send(16'h0000);
        wait_drain();

        // Partial frame plus dropped write, then reset: no residue afterwards.
        send(16'hFFFF); send(16'hFFFF);
        cfg(4, 1'b1, 4'd3);
        do_reset();
        cfg(0, 1'b1, 4'd1);
        expect_frame(16'h0003, 16'h0000);
        send(16'h8001); send(16'h0000); send(16'h0000); send(16'h0000);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sparse_mult_by_e_qc.md
# sparse_mult_by_e_qc

Parametrised quasi-cyclic sparse multiply-by-E for the LDPC encoder datapath: accepts one frame of NUM_IN_BLKS lifted blocks (WIDTH = lifting factor Z bits each) and produces NUM_OUT_BLKS blocks, each the GF(2) sum of circularly rotated input blocks selected by a runtime-programmable sparse shift table. It is the successor to the fixed single-block sparse multiplier. It adds channel generalisation, a loadable E matrix, and valid/ready handshaking on both sides. It sits between the information-bit packer and the dual-diagonal back-substitution stage.

## Interface
- WIDTH, 16, lifting factor Z in bits per block; must be ≥ 2.
- NUM_IN_BLKS, 4, input blocks per frame (columns of E).
- NUM_OUT_BLKS, 2, output blocks per frame (rows of E).
- Derived: SW = $clog2(WIDTH); AW = $clog2(NUM_IN_BLKS*NUM_OUT_BLKS).
- i_clock  in  1  single clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_in_data  in  WIDTH  input block.
- i_in_valid  in  1  input block valid.
- o_in_ready  out  1  block accepted when i_in_valid && o_in_ready.
- o_out_data  out  WIDTH  output block.
- o_out_valid  out  1  output block valid.
- o_out_last  out  1  marks block NUM_OUT_BLKS-1 of a frame.
- i_out_ready  in  1  output consumed when o_out_valid && i_out_ready.
- i_cfg_we  in  1  table write strobe.
- i_cfg_addr  in  AW  entry index = row*NUM_IN_BLKS + col.
- i_cfg_en  in  1  entry non-zero (circulant present).
- i_cfg_shift  in  SW  circulant shift for the entry.

## Operation
- Table: NUM_OUT_BLKS*NUM_IN_BLKS entries of {en, shift}. Reset value: all en=0, shift=0. An entry with shift ≥ WIDTH is treated as en=0. Writes to addresses ≥ NUM_IN_BLKS*NUM_OUT_BLKS are ignored.
- Rotation: rotl(x,s) = {x[WIDTH-1-s:0], x[WIDTH-1:WIDTH-s]}; s=0 gives x.
- State ACCUM:
  - o_in_ready=1.
  - On accept of block col c (input counter value), for every row r with entry (r,c) enabled: acc[r] ^= rotl(i_in_data, shift(r,c)).
  - Counter increments. On accept with c = NUM_IN_BLKS-1: counter←0 and go to DRAIN.
- State DRAIN:
  - o_in_ready=0; input valid is ignored.
  - o_out_valid=1; o_out_data=acc[row_idx]; o_out_last=(row_idx==NUM_OUT_BLKS-1).
  - On output handshake, row_idx increments.
  - On the handshake with last: all acc←0, row_idx←0, go to ACCUM.
- Config writes are applied only in ACCUM with input counter = 0 (no block of the current frame accepted). All other config writes are dropped silently.
- Reset (at any time, including mid-frame or mid-drain) sets:
  - state ACCUM, counters 0, acc all 0, table cleared;
  - o_out_valid=0, o_out_last=0, o_out_data=0;
  - o_in_ready=0 while i_reset is high.
- Any partial frame in progress at reset is discarded.

## Timing
- Latency: the block accepted on edge t as the final input of a frame gives o_out_valid=1 with acc[0] from cycle t+1. Its contribution is included.
- With i_out_ready held high, the drain takes exactly NUM_OUT_BLKS cycles. o_in_ready returns to 1 in the cycle after the last handshake.
- Sustained throughput: NUM_IN_BLKS + NUM_OUT_BLKS cycles per frame.
- o_out_data, o_out_valid and o_out_last stay stable while o_out_valid && !i_out_ready.
- o_in_ready and o_out_valid are never both 1.
- A config write accepted on edge t is used for blocks accepted from edge t+1 onward.
- All outputs are driven from registered state. No combinational path exists from i_out_ready or i_in_valid to any output.

## Test plan
(WIDTH=16, NUM_IN_BLKS=4, NUM_OUT_BLKS=2)
- Reset, i_in_valid=0 for 1000 cycles -> zero o_out_valid pulses; o_in_ready=1 after reset release.
- Default table, feed 0xFFFF ×4 -> outputs 0x0000, then 0x0000 with o_out_last=1; first valid 1 cycle after the 4th accept.
- Program (0,0)={1,1}; feed 0x8001,0,0,0 -> out0=0x0003, out1=0x0000.
- Program (0,0)={1,0}, (0,1)={1,0}, (1,3)={1,15}; feed 0x00F0, 0x0F00, 0x1234, 0x0001 -> out0=0x0FF0, out1=0x8000.
- Repeat the previous frame with i_out_ready=0 for 3 cycles while out0 is presented, and pulse i_in_valid during that time:
  - out0 is held stable; o_in_ready stays 0; the pulses are ignored;
  - after release, out1 follows; the next frame is accepted normally.
- Accept 2 blocks, issue a config write, then assert reset mid-frame; reprogram (0,0)={1,1}, feed 0x8001,0,0,0 -> out0=0x0003, out1=0x0000.
  - The dropped mid-frame write has no effect.
  - The partial frame leaves no residue.
